mux_nto1_pipe: RTL and testbench
================================

// Module: mux_nto1_pipe
// PURPOSE
//   Parametrised, registered N-to-1 datapath mux with a valid/ready handshake and a
//   2-entry skid buffer.
//   - Generalises the CPU's 2:1 combinational mux to NUM_IN channels of DATA_W bits.
//   - Lets pipelined-CPU stages (forwarding, writeback select) register the selected
//     value and absorb back-pressure at full throughput.
//   - Flags out-of-range selects with a sticky error.
// PARAMETERS
//   DATA_W  32  width of each data channel and of data_o
//   NUM_IN  4   number of input channels, >= 2
//   SEL_W   2   select width; must satisfy 2**SEL_W >= NUM_IN (elaboration error otherwise)
// PORTS
//   clk_i      in   1              clock, rising edge
//   rst_i      in   1              asynchronous active-low reset
//   select_i   in   SEL_W          channel select, sampled with the accepted beat
//   data_i     in   NUM_IN*DATA_W  packed channels; channel k = data_i[k*DATA_W +: DATA_W]
//   valid_i    in   1              upstream beat valid
//   ready_o    out  1              block can accept a beat this cycle
//   data_o     out  DATA_W         selected, registered data
//   valid_o    out  1              data_o holds a valid beat
//   ready_i    in   1              downstream accepts data_o this cycle
//   sel_err_o  out  1              sticky: an accepted beat had select_i >= NUM_IN
//   clr_err_i  in   1              synchronous clear of sel_err_o
// BEHAVIOUR
// - Reset (rst_i=0, async): data_o=0, valid_o=0, ready_o=0, sel_err_o=0, skid empty.
//   - ready_o rises on the first clk_i edge after rst_i deasserts.
//   - Reset mid-transfer discards all held beats.
// - Handshakes:
//   - Accept: valid_i & ready_o at a clk_i edge.
//   - Deliver: valid_o & ready_i at a clk_i edge.
// - Latency 1: a beat accepted at edge N appears on data_o/valid_o after edge N (empty block).
// - Storage: output register (OUT) plus one skid register (SKID). ready_o = ~SKID.valid,
//   registered.
// - Per-edge transitions, with acc = accept and dlv = deliver:
//   - OUT empty, acc:            beat -> OUT.
//   - OUT full, dlv, acc:        beat -> OUT (SKID empty by construction).
//   - OUT full, ~dlv, acc:       beat -> SKID; ready_o drops next cycle.
//   - OUT full, dlv, SKID full:  SKID -> OUT, SKID cleared; ready_o rises next cycle.
//   - OUT full, dlv, no new beat, SKID empty: valid_o -> 0 (data_o holds last value).
// - Stability and ordering:
//   - While valid_o & ~ready_i, data_o and valid_o stay stable.
//   - Beats delivered strictly in accept order; none dropped or duplicated.
// - Throughput: one beat per cycle while ready_i=1 and valid_i=1.
// - Selection:
//   - Captured value = channel select_i when select_i < NUM_IN.
//   - Otherwise DATA_W'b0 is captured; the beat is still valid and transferred.
// - Error flag:
//   - sel_err_o sets at the edge accepting an out-of-range select and holds until
//     clr_err_i=1 at an edge.
//   - Simultaneous clear and new error: set wins.
//   - Unaccepted beats (valid_i=0 or ready_o=0) never affect sel_err_o.
// - Inputs are ignored when valid_i & ready_o is false. No X propagation from unselected
//   channels.
// TESTING
// 1. Reset, then NUM_IN=4, ready_i=1, send sel=0..3 with ch k=32'hA000_000k
//    -> data_o = A0000000..A0000003 on consecutive cycles, 1-cycle latency, no bubbles.
// 2. ready_i=0 for 3 cycles while streaming beats 1,2,3 (sel=1, ch1 = beat value)
//    -> OUT holds 1, SKID holds 2, ready_o=0 from the cycle after the 2nd accept.
//    -> On ready_i=1: 1 then 2, then 3 after re-accept; no loss or duplication.
// 3. NUM_IN=3, SEL_W=2, accept sel=3 -> data_o=0, valid_o=1, sel_err_o=1 next cycle.
//    -> sel_err_o stays 1 through later good beats until clr_err_i pulses.
// 4. clr_err_i=1 on the same edge as another accepted sel=3 -> sel_err_o remains 1.
// 5. Assert rst_i=0 asynchronously with OUT and SKID full
//    -> valid_o, data_o, ready_o, sel_err_o go 0 immediately.
//    -> ready_o returns 1 one edge after release.
// 6. Random valid_i/ready_i toggling, 10k beats, DATA_W=8, NUM_IN=5
//    -> scoreboard matches order, zero drops, data_o stable while stalled.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 mux with valid/ready handshake and a 2-entry (OUT + SKID) buffer.
// Out-of-range selects capture zero and raise a sticky error flag.
module mux_nto1_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SEL_W-1:0]         select_i,
  input  logic [NUM_IN*DATA_W-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     sel_err_o,
  input  logic                     clr_err_i
);

  if ((2 ** SEL_W) < NUM_IN || NUM_IN < 2) begin : g_param_check
    $error("mux_nto1_pipe: SEL_W too small for NUM_IN, or NUM_IN < 2");
  end

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] beat_data;
  logic              sel_bad;
  logic              acc, dlv;

  // Compare against each legal index so unselected channels never leak X.
  always_comb begin
    beat_data = '0;
    sel_bad   = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) begin
        beat_data = data_i[k*DATA_W +: DATA_W];
        sel_bad   = 1'b0;
      end
    end
  end

  assign acc = valid_i & ready_q;
  assign dlv = out_valid_q & ready_i;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q) begin
      if (acc) begin
        out_data_d  = beat_data;
        out_valid_d = 1'b1;
      end
    end else if (dlv) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        out_data_d = beat_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_data_d  = beat_data;
      skid_valid_d = 1'b1;
    end
    ready_d = ~skid_valid_d;
  end

  // Set wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (clr_err_i) begin
      err_d = 1'b0;
    end
    if (acc && sel_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
    end
  end

  assign data_o    = out_data_q;
  assign valid_o   = out_valid_q;
  assign ready_o   = ready_q;
  assign sel_err_o = err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed and random checks of mux_nto1_pipe against a queue scoreboard and error-flag model.
module tb_mux_nto1_pipe;
  localparam int unsigned DW = 16;
  localparam int unsigned NI = 5;
  localparam int unsigned SW = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [SW-1:0]     select_i;
  logic [NI*DW-1:0]  data_i;
  logic              valid_i;
  logic              ready_o;
  logic [DW-1:0]     data_o;
  logic              valid_o;
  logic              ready_i;
  logic              sel_err_o;
  logic              clr_err_i;

  always #5 clk_i = ~clk_i;

  mux_nto1_pipe #(
    .DATA_W (DW),
    .NUM_IN (NI),
    .SEL_W  (SW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .select_i  (select_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sel_err_o (sel_err_o),
    .clr_err_i (clr_err_i)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [DW-1:0] sb_q[$];
  logic        err_m = 1'b0;
  logic        stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  int          acc_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model_sel(input logic [SW-1:0] s, input logic [NI*DW-1:0] d);
    if (32'(s) < NI) return d[32'(s)*DW +: DW];
    return '0;
  endfunction

  task automatic set_ch(input int unsigned k, input logic [DW-1:0] v);
    data_i[k*DW +: DW] = v;
  endtask

  // One clock: check/score at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [DW-1:0] exp_d;
    @(negedge clk_i);
    if (stall_prev) begin
      chk("stable_valid", 32'(valid_o), 32'd1);
      chk("stable_data", 32'(data_o), 32'(data_prev));
    end
    if (valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 32'd1);
      end else begin
        exp_d = sb_q.pop_front();
        chk("sb_data", 32'(data_o), 32'(exp_d));
      end
    end
    chk("sel_err", 32'(sel_err_o), 32'(err_m));
    if (clr_err_i) err_m = 1'b0;
    if (valid_i && ready_o) begin
      sb_q.push_back(model_sel(select_i, data_i));
      if (32'(select_i) >= NI) err_m = 1'b1;
    end
    stall_prev = valid_o && !ready_i;
    data_prev  = data_o;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i     = 1'b1;
    select_i  = '0;
    data_i    = '0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    clr_err_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_err", 32'(sel_err_o), 32'd0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 chk("ready_held_low", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #1 chk("ready_rise", 32'(ready_o), 32'd1);

    // Stream every channel at full rate.
    for (int unsigned k = 0; k < NI; k++) set_ch(k, 16'hA000 + 16'(k));
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int unsigned s = 0; s < NI; s++) begin
      select_i = SW'(s);
      step();
      chk("t1_valid", 32'(valid_o), 32'd1);
      chk("t1_data", 32'(data_o), 32'h0000_A000 + s);
    end
    valid_i = 1'b0;
    step();
    chk("t1_drain", 32'(valid_o), 32'd0);

    // Back-pressure fills OUT then SKID.
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    select_i = 3'd1;
    set_ch(1, 16'd1);
    step();
    chk("t2_ready_after1", 32'(ready_o), 32'd1);
    set_ch(1, 16'd2);
    step();
    chk("t2_ready_low", 32'(ready_o), 32'd0);
    set_ch(1, 16'd3);
    step();
    chk("t2_hold_ready", 32'(ready_o), 32'd0);
    chk("t2_hold_data", 32'(data_o), 32'd1);
    ready_i = 1'b1;
    step();
    chk("t2_skid_out", 32'(data_o), 32'd2);
    chk("t2_ready_back", 32'(ready_o), 32'd1);
    step();
    chk("t2_third", 32'(data_o), 32'd3);
    valid_i = 1'b0;
    step();
    chk("t2_empty", 32'(valid_o), 32'd0);

    // Out-of-range select.
    for (int unsigned k = 0; k < NI; k++) set_ch(k, 16'h1234 + 16'(k));
    valid_i  = 1'b1;
    select_i = 3'd6;
    step();
    chk("t3_zero", 32'(data_o), 32'd0);
    chk("t3_valid", 32'(valid_o), 32'd1);
    chk("t3_err", 32'(sel_err_o), 32'd1);
    select_i = 3'd2;
    step();
    step();
    chk("t3_sticky", 32'(sel_err_o), 32'd1);
    valid_i   = 1'b0;
    select_i  = 3'd7;
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    chk("t3_cleared", 32'(sel_err_o), 32'd0);
    step();
    chk("t3_unaccepted", 32'(sel_err_o), 32'd0);

    // Clear and new error on the same edge.
    valid_i  = 1'b1;
    select_i = 3'd7;
    step();
    select_i  = 3'd5;
    clr_err_i = 1'b1;
    step();
    chk("t4_set_wins", 32'(sel_err_o), 32'd1);
    valid_i = 1'b0;
    step();
    clr_err_i = 1'b0;
    step();

    // Async reset with OUT and SKID full.
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    select_i = 3'd1;
    set_ch(1, 16'h0055);
    step();
    select_i = 3'd7;
    step();
    chk("t5_full_ready", 32'(ready_o), 32'd0);
    chk("t5_full_err", 32'(sel_err_o), 32'd1);
    valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("t5_valid", 32'(valid_o), 32'd0);
    chk("t5_data", 32'(data_o), 32'd0);
    chk("t5_ready", 32'(ready_o), 32'd0);
    chk("t5_err", 32'(sel_err_o), 32'd0);
    sb_q.delete();
    err_m      = 1'b0;
    stall_prev = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("t5_ready_rise", 32'(ready_o), 32'd1);
    chk("t5_empty", 32'(valid_o), 32'd0);

    // Random handshake traffic, including bad selects and clears.
    for (int c = 0; c < 60000 && acc_cnt < 10000; c++) begin
      valid_i   = ($urandom_range(3) != 0);
      ready_i   = ($urandom_range(3) != 0);
      clr_err_i = ($urandom_range(7) == 0);
      select_i  = SW'($urandom_range(7));
      for (int unsigned k = 0; k < NI; k++) set_ch(k, DW'($urandom));
      if (valid_i && ready_o) acc_cnt++;
      step();
    end
    chk("t6_accepts", 32'(acc_cnt), 32'd10000);
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    clr_err_i = 1'b0;
    for (int c = 0; c < 10 && (sb_q.size() != 0 || valid_o); c++) step();
    chk("t6_drained", sb_q.size(), 32'd0);
    chk("t6_idle", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
